// File: rtl/ot_clk_div_ctrl.sv
// ot_clk_div_ctrl
// Glitch-safe clock-enable divider for the OT clock domain.
// A new divide ratio written by the control register block is held as a
// pending value and only takes effect at a period boundary (or right away
// while the divider is stopped), so the downstream gate never sees a runt.
// Gate-off requests also wait for the current period to finish.
//
// Optional build feature: define OT_CLK_DIV_PERIOD_CNT_EN to build a 32-bit
// completed-period counter on period_cnt_o; otherwise the port is tied to 0.

module ot_clk_div_ctrl #(
   parameter int unsigned DIV_W   = 32,
   parameter int unsigned RST_DIV = 32'd1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [DIV_W-1:0] div_q_i,
   input  logic             div_qe_i,
   input  logic             gate_en_i,
   output logic             clk_en_o,
   output logic             clk_div_o,
   output logic             gate_en_o,
   output logic             busy_o,
   output logic [31:0]      period_cnt_o
);

   typedef enum logic [0:0] {
      ST_OFF = 1'b0,
      ST_RUN = 1'b1
   } state_e;

   state_e           state_q;
   state_e           state_d;
   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic [DIV_W-1:0] pend_div_q;
   logic [DIV_W-1:0] pend_div_d;
   logic             pend_q;
   logic             pend_d;

   logic [DIV_W-1:0] ne;
   logic [DIV_W-1:0] high_len;
   logic             wrap;
   logic             running;

   // Effective ratio, boundary detect and high-phase length (ceil(Ne/2))
   always_comb begin
      running  = (state_q == ST_RUN);
      ne       = (div_q == {DIV_W{1'b0}}) ? DIV_W'(1) : div_q;
      wrap     = running && (cnt_q == (ne - DIV_W'(1)));
      high_len = (ne >> 1) + {{(DIV_W-1){1'b0}}, ne[0]};
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_OFF;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: start on request, stop only at a period boundary
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_OFF: begin
            if (gate_en_i) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_OFF;
            end
         end
         ST_RUN: begin
            if (wrap && !gate_en_i) begin
               state_d = ST_OFF;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_OFF;
         end
      endcase
   end

   // Period counter next value: count while running, restart at boundary
   always_comb begin
      cnt_d = {DIV_W{1'b0}};
      if (running && !wrap) begin
         cnt_d = cnt_q + DIV_W'(1);
      end else begin
         cnt_d = {DIV_W{1'b0}};
      end
   end

   // Ratio capture/apply: strobe on a boundary bypasses the pending slot;
   // otherwise the pending value is applied at the next boundary or at once
   // while stopped
   always_comb begin
      div_d      = div_q;
      pend_d     = pend_q;
      pend_div_d = pend_div_q;
      if (div_qe_i && wrap) begin
         div_d  = div_q_i;
         pend_d = 1'b0;
      end else if (div_qe_i) begin
         if (pend_q && !running) begin
            div_d = pend_div_q;
         end else begin
            div_d = div_q;
         end
         pend_div_d = div_q_i;
         pend_d     = 1'b1;
      end else if (pend_q && (wrap || !running)) begin
         div_d  = pend_div_q;
         pend_d = 1'b0;
      end else begin
         div_d  = div_q;
         pend_d = pend_q;
      end
   end

   // Datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q      <= {DIV_W{1'b0}};
         div_q      <= DIV_W'(RST_DIV);
         pend_div_q <= {DIV_W{1'b0}};
         pend_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         pend_div_q <= pend_div_d;
         pend_q     <= pend_d;
      end
   end

`ifdef OT_CLK_DIV_PERIOD_CNT_EN
   logic [31:0] period_cnt_q;

   // Completed-period counter, free-running modulo 2^32
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         period_cnt_q <= 32'd0;
      end else if (wrap) begin
         period_cnt_q <= period_cnt_q + 32'd1;
      end else begin
         period_cnt_q <= period_cnt_q;
      end
   end

   assign period_cnt_o = period_cnt_q;
`else
   assign period_cnt_o = 32'd0;
`endif

   assign clk_en_o  = wrap;
   assign clk_div_o = running && (cnt_q < high_len);
   assign gate_en_o = running;
   assign busy_o    = pend_q;

endmodule

// File: tb/tb_ot_clk_div_ctrl.sv
// tb_ot_clk_div_ctrl
// Directed scenarios followed by random traffic, all checked every cycle
// against a period-level behavioural model of the divider.

module tb_ot_clk_div_ctrl;

   localparam int DIV_W   = 8;
   localparam int RST_DIV = 1;

   logic             clk = 1'b0;
   logic             rst_ni = 1'b0;
   logic [DIV_W-1:0] div_q_i = '0;
   logic             div_qe_i = 1'b0;
   logic             gate_en_i = 1'b0;
   logic             clk_en_o;
   logic             clk_div_o;
   logic             gate_en_o;
   logic             busy_o;
   logic [31:0]      period_cnt_o;

   int tests_run = 0;
   int tests_failed = 0;

   // Model: is the divided clock running, how far into the period are we,
   // which ratio is in force, and is a new ratio waiting
   bit          m_run;
   int          m_pos;
   int          m_ratio;
   int          m_next_ratio;
   bit          m_waiting;
   logic [31:0] m_periods;

   ot_clk_div_ctrl #(
      .DIV_W  (DIV_W),
      .RST_DIV(RST_DIV)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .div_q_i     (div_q_i),
      .div_qe_i    (div_qe_i),
      .gate_en_i   (gate_en_i),
      .clk_en_o    (clk_en_o),
      .clk_div_o   (clk_div_o),
      .gate_en_o   (gate_en_o),
      .busy_o      (busy_o),
      .period_cnt_o(period_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int eff_ratio();
      return (m_ratio == 0) ? 1 : m_ratio;
   endfunction

   function automatic bit period_end();
      return m_run && (m_pos == eff_ratio() - 1);
   endfunction

   task automatic model_reset();
      m_run        = 1'b0;
      m_pos        = 0;
      m_ratio      = RST_DIV;
      m_next_ratio = 0;
      m_waiting    = 1'b0;
      m_periods    = 32'd0;
   endtask

   // Advance the model by one clock edge using the inputs the DUT samples
   task automatic model_edge();
      bit ends;
      ends = period_end();
      if (ends) m_periods = m_periods + 32'd1;
      if (ends) begin
         if (div_qe_i) m_ratio = int'(div_q_i);
         else if (m_waiting) m_ratio = m_next_ratio;
         m_waiting = 1'b0;
      end else if (!m_run && m_waiting) begin
         m_ratio   = m_next_ratio;
         m_waiting = 1'b0;
      end
      if (div_qe_i && !ends) begin
         m_next_ratio = int'(div_q_i);
         m_waiting    = 1'b1;
      end
      m_pos = (m_run && !ends) ? m_pos + 1 : 0;
      if (m_run) m_run = !(ends && !gate_en_i);
      else       m_run = gate_en_i;
   endtask

   task automatic check_outputs();
      logic [31:0] exp_cnt;
`ifdef OT_CLK_DIV_PERIOD_CNT_EN
      exp_cnt = m_periods;
`else
      exp_cnt = 32'd0;
`endif
      check_eq("clk_en", {31'd0, clk_en_o}, {31'd0, period_end()});
      check_eq("clk_div", {31'd0, clk_div_o},
               {31'd0, (m_run && (m_pos < (eff_ratio() + 1) / 2))});
      check_eq("gate_en", {31'd0, gate_en_o}, {31'd0, m_run});
      check_eq("busy", {31'd0, busy_o}, {31'd0, m_waiting});
      check_eq("period_cnt", period_cnt_o, exp_cnt);
   endtask

   // Drive inputs for one cycle (called just after a falling edge)
   task automatic cycle(input logic qe, input logic [DIV_W-1:0] dq, input logic gen);
      div_qe_i  = qe;
      div_q_i   = dq;
      gate_en_i = gen;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n, input logic gen);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, gen);
   endtask

   // Run with the gate on until the current cycle is a period end
   task automatic wait_period_end(input string tag);
      int budget;
      budget = 64;
      while (!period_end() && budget > 0) begin
         cycle(1'b0, '0, 1'b1);
         budget--;
      end
      check_eq(tag, {31'd0, period_end()}, 32'd1);
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_outputs();
      rst_ni = 1'b1;

      // Divide-by-1 start-up
      idle(6, 1'b1);
      idle(3, 1'b0);

      // Ratio 4 written while off, then enable
      cycle(1'b1, 8'd4, 1'b0);
      idle(2, 1'b0);
      idle(12, 1'b1);

      // Ratio 5 written mid-period while running at 4
      idle(1, 1'b1);
      cycle(1'b1, 8'd5, 1'b1);
      idle(14, 1'b1);

      // Back to 4, then strobe 3 exactly on a boundary
      cycle(1'b1, 8'd4, 1'b1);
      idle(10, 1'b1);
      wait_period_end("wait_wrap_a");
      cycle(1'b1, 8'd3, 1'b1);
      idle(8, 1'b1);

      // Ratio 4, drop the gate one cycle into a period
      cycle(1'b1, 8'd4, 1'b1);
      idle(4, 1'b1);
      wait_period_end("wait_wrap_b");
      idle(2, 1'b1);
      check_eq("mid_pos", m_pos, 32'd1);
      idle(6, 1'b0);

      // Ratio 2 for ten periods
      cycle(1'b1, 8'd2, 1'b0);
      idle(1, 1'b0);
      idle(20, 1'b1);

      // Asynchronous reset in the middle of a period
      cycle(1'b1, 8'd4, 1'b1);
      idle(6, 1'b1);
      #2 rst_ni = 1'b0;
      #1;
      check_eq("rst_clk_en", {31'd0, clk_en_o}, 32'd0);
      check_eq("rst_clk_div", {31'd0, clk_div_o}, 32'd0);
      check_eq("rst_gate_en", {31'd0, gate_en_o}, 32'd0);
      check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
      check_eq("rst_period_cnt", period_cnt_o, 32'd0);
      model_reset();
      @(negedge clk);
      check_outputs();
      rst_ni = 1'b1;

      // Random traffic
      begin
         logic gen;
         gen = 1'b1;
         for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) gen = ~gen;
            cycle(($urandom_range(0, 7) == 0), 8'($urandom_range(0, 7)), gen);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
